// File: rtl/defs_pkg.sv
// Shared type definitions for the CPU control path and the memory responder.
package defs_pkg;

  localparam int unsigned WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mem_state_t;

  typedef enum logic [2:0] {
    CPU_FETCH,
    CPU_DECODE,
    CPU_EXECUTE,
    CPU_MEM,
    CPU_WRITEBACK
  } cpu_state_t;

  typedef struct packed {
    logic       reg_we;
    logic       mem_rd;
    logic       mem_wr;
    logic       branch;
    logic [1:0] alu_sel;
  } ctrl_t;

  // Counter value loaded on WAIT entry; zero wait states never enter WAIT.
  function automatic logic [WAIT_CNT_W-1:0] wait_load(input int unsigned cycles);
    return (cycles == 0) ? '0 : WAIT_CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/sp_ram.sv
// Single-port storage: synchronous write, combinational read of the addressed word, no reset.
module sp_ram #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata_c
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [IDX_W-1:0]      idx_c;

  // Callers only write in-range addresses, so truncation cannot alias a write.
  assign idx_c   = IDX_W'(addr);
  assign rdata_c = mem[idx_c];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx_c] <= wdata;
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Wait-state memory responder: captures a request in IDLE, waits WAIT_CYCLES, then
// commits the write or returns read data with a one-cycle done pulse.
module mem_responder
  import defs_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_done,
  output logic                  mem_err,
  output logic                  mem_busy
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = wait_load(WAIT_CYCLES);
  localparam bit                    NO_WAIT   = (WAIT_CYCLES == 0);

  mem_state_t            state;
  logic [WAIT_CNT_W-1:0] cnt;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic                  accept_c;
  logic                  fire_c;
  logic                  sel_we_c;
  logic [ADDR_WIDTH-1:0] sel_addr_c;
  logic [DATA_WIDTH-1:0] sel_wdata_c;
  logic                  in_range_c;
  logic                  ram_we_c;
  logic [DATA_WIDTH-1:0] ram_rdata_c;

  // With zero wait states the access fires on the accepting edge, so it uses the live inputs.
  always_comb begin
    accept_c    = (state == IDLE) && mem_req;
    fire_c      = ((state == WAIT) && (cnt == '0)) || (accept_c && NO_WAIT);
    sel_we_c    = (state == IDLE) ? mem_we    : we_q;
    sel_addr_c  = (state == IDLE) ? mem_addr  : addr_q;
    sel_wdata_c = (state == IDLE) ? mem_wdata : wdata_q;
    in_range_c  = 32'(sel_addr_c) < DEPTH;
    ram_we_c    = fire_c && sel_we_c && in_range_c && resetn;
  end

  sp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we      (ram_we_c),
    .addr    (sel_addr_c),
    .wdata   (sel_wdata_c),
    .rdata_c (ram_rdata_c)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      mem_rdata <= '0;
      mem_done  <= 1'b0;
      mem_err   <= 1'b0;
      mem_busy  <= 1'b0;
    end else begin
      mem_done <= 1'b0;
      mem_err  <= 1'b0;

      case (state)
        IDLE: begin
          if (mem_req) begin
            we_q     <= mem_we;
            addr_q   <= mem_addr;
            wdata_q  <= mem_wdata;
            mem_busy <= 1'b1;
            if (NO_WAIT) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= WAIT_LOAD;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state <= RESP;
          end else begin
            cnt <= cnt - WAIT_CNT_W'(1);
          end
        end
        RESP: begin
          state    <= IDLE;
          mem_busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          mem_busy <= 1'b0;
        end
      endcase

      // Response is registered on the edge entering RESP; writes leave mem_rdata untouched.
      if (fire_c) begin
        mem_done <= 1'b1;
        mem_err  <= !in_range_c;
        if (!in_range_c) begin
          mem_rdata <= '0;
        end else if (!sel_we_c) begin
          mem_rdata <= ram_rdata_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (2 wait states / depth 200, and 0 wait states / depth 256).
module tb_mem_responder;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 8;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                resetn;
  logic [1:0]          req;
  logic [1:0]          we;
  logic [1:0][AW-1:0]  addr;
  logic [1:0][DW-1:0]  wdata;
  logic [1:0][DW-1:0]  rdata;
  logic [1:0]          done;
  logic [1:0]          err;
  logic [1:0]          busy;

  int checks = 0;
  int passes = 0;

  exp_t          sb0[$];
  exp_t          sb1[$];
  logic [DW-1:0] model [2][256];
  logic [DW-1:0] last_rd [2];

  mem_responder #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH      (200),
    .WAIT_CYCLES(2)
  ) dut_a (
    .clk       (clk),
    .resetn    (resetn),
    .mem_req   (req[0]),
    .mem_we    (we[0]),
    .mem_addr  (addr[0]),
    .mem_wdata (wdata[0]),
    .mem_rdata (rdata[0]),
    .mem_done  (done[0]),
    .mem_err   (err[0]),
    .mem_busy  (busy[0])
  );

  mem_responder #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH      (256),
    .WAIT_CYCLES(0)
  ) dut_b (
    .clk       (clk),
    .resetn    (resetn),
    .mem_req   (req[1]),
    .mem_we    (we[1]),
    .mem_addr  (addr[1]),
    .mem_wdata (wdata[1]),
    .mem_rdata (rdata[1]),
    .mem_done  (done[1]),
    .mem_err   (err[1]),
    .mem_busy  (busy[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic check_idle_outputs(input string tag);
    for (int s = 0; s < 2; s++) begin
      check($sformatf("%s_rdata%0d", tag, s), 32'(rdata[s]), 32'(0));
      check($sformatf("%s_done%0d", tag, s), 32'(done[s]), 32'(0));
      check($sformatf("%s_err%0d", tag, s), 32'(err[s]), 32'(0));
      check($sformatf("%s_busy%0d", tag, s), 32'(busy[s]), 32'(0));
    end
  endtask

  // Scoreboard pop on every done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (done[0]) begin
      check("a_sb_nonempty", 32'(sb0.size() > 0), 32'(1));
      if (sb0.size() > 0) begin
        e = sb0.pop_front();
        check("a_rdata", 32'(rdata[0]), 32'(e.rdata));
        check("a_err", 32'(err[0]), 32'(e.err));
      end
    end
    if (done[1]) begin
      check("b_sb_nonempty", 32'(sb1.size() > 0), 32'(1));
      if (sb1.size() > 0) begin
        e = sb1.pop_front();
        check("b_rdata", 32'(rdata[1]), 32'(e.rdata));
        check("b_err", 32'(err[1]), 32'(e.err));
      end
    end
  end

  task automatic push_exp(input int s, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int unsigned depth = (s == 0) ? 200 : 256;
    logic        in_r  = 32'(a) < depth;
    exp_t        e;
    if (!in_r)  e.rdata = '0;
    else if (w) e.rdata = last_rd[s];
    else        e.rdata = model[s][a];
    e.err     = !in_r;
    last_rd[s] = e.rdata;
    if (w && in_r) model[s][a] = d;
    if (s == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endtask

  // One access with busy/done timing checks; scramble drives junk (req held) during WAIT.
  task automatic access(input int s, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input bit scramble);
    int wc = (s == 0) ? 2 : 0;
    @(negedge clk);
    req[s] = 1'b1; we[s] = w; addr[s] = a; wdata[s] = d;
    @(posedge clk);
    push_exp(s, w, a, d);
    for (int i = 0; i <= wc; i++) begin
      @(negedge clk);
      check($sformatf("busy%0d_c%0d", s, i), 32'(busy[s]), 32'(1));
      check($sformatf("done%0d_c%0d", s, i), 32'(done[s]), 32'(i == wc));
      if (scramble && i < wc) begin
        addr[s]  = AW'($urandom);
        wdata[s] = DW'($urandom);
        we[s]    = 1'($urandom);
      end else begin
        req[s] = 1'b0;
      end
    end
    @(negedge clk);
    check($sformatf("busy%0d_after", s), 32'(busy[s]), 32'(0));
    check($sformatf("done%0d_after", s), 32'(done[s]), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0;
    req = '0; we = '0; addr = '0; wdata = '0;
    last_rd[0] = '0;
    last_rd[1] = '0;
    #12;
    check_idle_outputs("reset");
    @(negedge clk);
    resetn = 1'b1;

    // Write then read back with two wait states.
    access(0, 1'b1, 8'h10, 16'hBEEF, 1'b0);
    access(0, 1'b0, 8'h10, 16'h0000, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("a_rdata_hold", 32'(rdata[0]), 32'(16'hBEEF));
    end
    access(0, 1'b1, 8'h11, 16'h4321, 1'b0);
    check("a_rdata_after_write", 32'(rdata[0]), 32'(16'hBEEF));

    // Out-of-range and last in-range address.
    access(0, 1'b1, 8'hC8, 16'h1234, 1'b0);
    access(0, 1'b0, 8'hC8, 16'h0000, 1'b0);
    access(0, 1'b1, 8'd199, 16'h5A5A, 1'b0);
    access(0, 1'b0, 8'd199, 16'h0000, 1'b0);
    access(0, 1'b0, 8'hFF, 16'h0000, 1'b0);

    // Inputs changing during WAIT must not affect the captured access.
    access(0, 1'b1, 8'h21, 16'h0101, 1'b0);
    access(0, 1'b1, 8'h20, 16'h7777, 1'b1);
    access(0, 1'b0, 8'h20, 16'h0000, 1'b0);
    access(0, 1'b0, 8'h21, 16'h0000, 1'b0);

    // Reset mid-WAIT aborts the write.
    access(0, 1'b1, 8'h05, 16'h5555, 1'b0);
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 8'h05; wdata[0] = 16'hAAAA;
    @(posedge clk);
    @(negedge clk);
    req[0] = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    check_idle_outputs("midwait_reset");
    @(negedge clk);
    check_idle_outputs("reset_hold");
    resetn = 1'b1;
    last_rd[0] = '0;
    last_rd[1] = '0;
    access(0, 1'b0, 8'h05, 16'h0000, 1'b0);

    // Zero wait states: back-to-back reads with req held high.
    access(1, 1'b1, 8'h00, 16'hC001, 1'b0);
    access(1, 1'b1, 8'h01, 16'hC002, 1'b0);
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 8'h00;
    push_exp(1, 1'b0, 8'h00, 16'h0000);
    push_exp(1, 1'b0, 8'h01, 16'h0000);
    @(negedge clk);
    check("b2b_done_c2", 32'(done[1]), 32'(1));
    check("b2b_busy_c2", 32'(busy[1]), 32'(1));
    addr[1] = 8'h01;
    @(negedge clk);
    check("b2b_done_c3", 32'(done[1]), 32'(0));
    check("b2b_busy_c3", 32'(busy[1]), 32'(0));
    @(negedge clk);
    check("b2b_done_c4", 32'(done[1]), 32'(1));
    req[1] = 1'b0;
    @(negedge clk);
    check("b2b_done_c5", 32'(done[1]), 32'(0));
    check("b_rdata_hold", 32'(rdata[1]), 32'(16'hC002));

    repeat (2) @(negedge clk);
    check("a_sb_drained", 32'(sb0.size()), 32'(0));
    check("b_sb_drained", 32'(sb1.size()), 32'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, memory word and bus width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, word-address width.
REQ-003 SHALL have parameter DEPTH, default 256, number of implemented words (DEPTH <= 2**ADDR_WIDTH).
REQ-004 SHALL have parameter WAIT_CYCLES, default 2, wait states per access (0..15 legal).
REQ-005 SHALL have one clock and an asynchronous, active-low reset; clk and resetn are the only clock and reset ports.
REQ-006 SHALL have port clk  input  1  rising-edge clock.
REQ-007 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-008 SHALL have port mem_req  input  1  access request from the control unit, sampled only in IDLE.
REQ-009 SHALL have port mem_we  input  1  1 = write, 0 = read, captured with mem_req.
REQ-010 SHALL have port mem_addr  input  ADDR_WIDTH  word address, captured with mem_req.
REQ-011 SHALL have port mem_wdata  input  DATA_WIDTH  write data, captured with mem_req.
REQ-012 SHALL have port mem_rdata  output  DATA_WIDTH  read data, registered.
REQ-013 SHALL have port mem_done  output  1  one-cycle completion pulse.
REQ-014 SHALL have port mem_err  output  1  out-of-range flag, valid only with mem_done.
REQ-015 SHALL have port mem_busy  output  1  high whenever state is not IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-017 In IDLE with mem_req=1, SHALL capture we/addr/wdata at the clock edge and move to WAIT, or to RESP directly if WAIT_CYCLES=0.
REQ-018 In WAIT, SHALL load a down-counter with WAIT_CYCLES-1 on entry, decrement each cycle, and go to RESP on the edge where the counter is 0.
REQ-019 SHALL commit a write, or register the read word into mem_rdata, on the edge entering RESP.
REQ-020 SHALL assert mem_done for exactly the one RESP cycle, then return to IDLE unconditionally.
REQ-021 Latency: if the request is accepted at edge k, mem_done SHALL be high in the cycle following edge k+WAIT_CYCLES.
REQ-022 SHALL ignore mem_req, mem_we, mem_addr and mem_wdata while in WAIT or RESP; if mem_req is still high in the following IDLE cycle, it is a new request.
REQ-023 If the captured addr >= DEPTH, SHALL perform no write, set mem_rdata to 0, and assert mem_err with mem_done.
REQ-024 SHALL hold mem_rdata at its last value outside RESP; a write access SHALL leave mem_rdata unchanged.
REQ-025 The minimum spacing between accepted requests SHALL be WAIT_CYCLES+2 cycles.

Reset
REQ-026 resetn=0 SHALL immediately force IDLE, counter=0, mem_rdata=0, mem_done=0, mem_err=0, mem_busy=0.
REQ-027 Reset asserted during WAIT SHALL abort the access, with no write committed.
REQ-028 Reset asserted in RESP SHALL NOT roll back an already-committed write.
REQ-029 Memory array contents SHALL NOT be reset.

Structure
REQ-030 The mem_state_t enum (IDLE, WAIT, RESP) SHALL be placed in defs_pkg next to the CPU state and control typedefs.
REQ-031 The storage array SHALL be a single sub-module sp_ram: synchronous single-port, one write or read per cycle, no reset.
REQ-032 The FSM, wait counter, request capture registers and range check SHALL reside in mem_responder.

Verification
REQ-033 Reset, then write 0xBEEF to addr 0x10 with WAIT_CYCLES=2 -> mem_busy high for 3 cycles, mem_done high 3 cycles after acceptance, mem_err=0.
REQ-034 Read addr 0x10 after REQ-033 -> mem_rdata=0xBEEF in the mem_done cycle, and held afterward.
REQ-035 WAIT_CYCLES=0, back-to-back reads of addr 0 and addr 1 with mem_req held high -> mem_done in cycles 2 and 4, each with the correct data.
REQ-036 DEPTH=200, write 0x1234 to addr 0xC8, then read 0xC8 -> mem_err=1 with mem_done both times, mem_rdata=0.
REQ-037 Write 0xAAAA to addr 5, assert resetn=0 mid-WAIT, release, then read addr 5 -> original contents returned, and all outputs 0 during reset.
REQ-038 Change mem_addr and mem_wdata during WAIT -> access uses the values captured at acceptance.
